// File: rtl/bc_pkg.sv
// Shared types and constants for the polynomial control block: FSM states,
// mux select encodings, ALU opcodes and the per-state control decode.
package bc_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL1 = 3'd2,
    ADD1 = 3'd3,
    MUL2 = 3'd4,
    ADD2 = 3'd5,
    DONE = 3'd6
  } state_t;

  // M0 (coefficient mux)
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

  // M1 (ALU operand 1)
  localparam logic [1:0] SEL_M0   = 2'd0;
  localparam logic [1:0] SEL_R0   = 2'd1;
  localparam logic [1:0] SEL_R1   = 2'd2;
  localparam logic [1:0] SEL_R2   = 2'd3;

  // M2 (ALU operand 2) orders R0 and the coefficient the other way round
  localparam logic [1:0] SEL2_R0  = 2'd0;
  localparam logic [1:0] SEL2_M0  = 2'd1;
  localparam logic [1:0] SEL2_R1  = 2'd2;
  localparam logic [1:0] SEL2_R2  = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       lx;
    logic       lh;
    logic       ls;
  } ctrl_t;

  // Selects are held for the whole step; load strobes only on its last cycle.
  function automatic ctrl_t step_ctrl(input state_t s, input logic last);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD: c.lx = last;
      MUL1: begin
        c.m0 = SEL_A;    c.m1 = SEL_M0; c.m2 = SEL2_R0; c.h = OP_MUL; c.lh = last;
      end
      ADD1: begin
        c.m0 = SEL_B;    c.m1 = SEL_R1; c.m2 = SEL2_M0; c.h = OP_ADD; c.lh = last;
      end
      MUL2: begin
        c.m0 = SEL_ZERO; c.m1 = SEL_R1; c.m2 = SEL2_R0; c.h = OP_MUL; c.lh = last;
      end
      ADD2: begin
        c.m0 = SEL_C;    c.m1 = SEL_R1; c.m2 = SEL2_M0; c.h = OP_ADD; c.ls = last;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bc_contador_passo.sv
// Step counter: counts 0..STEP_CYCLES-1 while enabled and flags the last
// cycle of the current sequence step.
module bc_contador_passo
  import bc_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CNT_W'(STEP_CYCLES - 1));

endmodule

// File: rtl/bloco_controle.sv
// Control block sequencing the 16-bit datapath through a Horner evaluation
// of y = A*x^2 + B*x + C. Moore FSM; outputs depend on state and step count only.
module bloco_controle
  import bc_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H
);

  state_t state_q;
  state_t state_d;
  logic   last;
  logic   counting;
  ctrl_t  ctrl;

  assign counting = state_q inside {LOAD, MUL1, ADD1, MUL2, ADD2};

  // Counter clears outside timed steps and on the edge that advances a step.
  bc_contador_passo #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_passo (
    .clk   (clk),
    .rst   (rst),
    .clear (!counting || last),
    .enable(counting),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (last)  state_d = MUL1;
      MUL1:    if (last)  state_d = ADD1;
      ADD1:    if (last)  state_d = MUL2;
      MUL2:    if (last)  state_d = ADD2;
      ADD2:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl = step_ctrl(state_q, last);
    M0   = ctrl.m0;
    M1   = ctrl.m1;
    M2   = ctrl.m2;
    H    = ctrl.h;
    LX   = ctrl.lx;
    LH   = ctrl.lh;
    LS   = ctrl.ls;
    busy = counting || (state_q == DONE);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: two instances (STEP_CYCLES 1 and 3) drive a
// behavioural datapath model; results are compared with y = A*x^2 + B*x + C.
module tb_bloco_controle;

  logic clk;
  logic rst;
  logic startV [2];

  logic busy1, done1, lx1, lh1, ls1, h1;
  logic [1:0] m0_1, m1_1, m2_1;
  logic busy3, done3, lx3, lh3, ls3, h3;
  logic [1:0] m0_3, m1_3, m2_3;

  // Observed control word: {busy, done, M0, M1, M2, LX, LH, LS, H}
  logic [11:0] obs [2];

  logic [15:0] opA [2];
  logic [15:0] opB [2];
  logic [15:0] opC [2];
  logic [15:0] xIn [2];
  logic [15:0] r0 [2] = '{16'h0, 16'h0};
  logic [15:0] r1 [2] = '{16'h0, 16'h0};
  logic [15:0] r2 [2] = '{16'h0, 16'h0};

  int checks = 0;
  int errors = 0;

  bloco_controle #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(startV[0]),
    .busy(busy1), .done(done1), .M0(m0_1), .M1(m1_1), .M2(m2_1),
    .LX(lx1), .LH(lh1), .LS(ls1), .H(h1)
  );

  bloco_controle #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(startV[1]),
    .busy(busy3), .done(done3), .M0(m0_3), .M1(m1_3), .M2(m2_3),
    .LX(lx3), .LH(lh3), .LS(ls3), .H(h3)
  );

  assign obs[0] = {busy1, done1, m0_1, m1_1, m2_1, lx1, lh1, ls1, h1};
  assign obs[1] = {busy3, done3, m0_3, m1_3, m2_3, lx3, lh3, ls3, h3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] aluOut(input int i);
    logic [15:0] m0v, op1, op2;
    case (obs[i][9:8])
      2'd0: m0v = 16'h0;
      2'd1: m0v = opA[i];
      2'd2: m0v = opB[i];
      default: m0v = opC[i];
    endcase
    case (obs[i][7:6])
      2'd0: op1 = m0v;
      2'd1: op1 = r0[i];
      2'd2: op1 = r1[i];
      default: op1 = r2[i];
    endcase
    case (obs[i][5:4])
      2'd0: op2 = r0[i];
      2'd1: op2 = m0v;
      2'd2: op2 = r1[i];
      default: op2 = r2[i];
    endcase
    return obs[i][0] ? op1 * op2 : op1 + op2;
  endfunction

  // Operational block model; keeps its registers across reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (obs[i][3]) r0[i] <= xIn[i];
      if (obs[i][2]) r1[i] <= aluOut(i);
      if (obs[i][1]) r2[i] <= aluOut(i);
    end
  end

  // Expected control word for cycle cyc after the start edge.
  function automatic logic [11:0] expWord(input int s, input int cyc);
    logic [1:0] m0, m1, m2;
    logic lx, lh, ls, h, bsy, dn, ld;
    int st;
    m0 = 0; m1 = 0; m2 = 0; lx = 0; lh = 0; ls = 0; h = 0; bsy = 0; dn = 0;
    if (cyc >= 1 && cyc <= 5 * s) begin
      bsy = 1;
      st  = (cyc - 1) / s;
      ld  = (((cyc - 1) % s) == s - 1);
      case (st)
        0: lx = ld;
        1: begin m0 = 2'd1; m1 = 2'd0; m2 = 2'd0; h = 1; lh = ld; end
        2: begin m0 = 2'd2; m1 = 2'd2; m2 = 2'd1; h = 0; lh = ld; end
        3: begin m0 = 2'd0; m1 = 2'd2; m2 = 2'd0; h = 1; lh = ld; end
        default: begin m0 = 2'd3; m1 = 2'd2; m2 = 2'd1; h = 0; ls = ld; end
      endcase
    end else if (cyc == 5 * s + 1) begin
      bsy = 1;
      dn  = 1;
    end
    return {bsy, dn, m0, m1, m2, lx, lh, ls, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] x);
    opA[idx] = a;
    opB[idx] = b;
    opC[idx] = c;
    xIn[idx] = x;
  endtask

  // Entered in an IDLE cycle; leaves in the IDLE cycle after DONE.
  task automatic runEval(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] x,
                         input bit midPulse, input bit holdAtDone);
    int s;
    logic [15:0] y;
    s = (idx == 0) ? 1 : 3;
    y = a * x * x + b * x + c;
    applyStimulus(idx, a, b, c, x);
    startV[idx] = 1'b1;
    tick();
    startV[idx] = 1'b0;
    for (int cyc = 1; cyc <= 5 * s + 1; cyc++) begin
      checkOutput($sformatf("ctl_s%0d_c%0d", s, cyc), {4'h0, obs[idx]}, {4'h0, expWord(s, cyc)});
      if (cyc == 5 * s + 1) checkOutput($sformatf("pronto_s%0d", s), r2[idx], y);
      startV[idx] = (midPulse && cyc == 3 * s + 1) || (holdAtDone && cyc == 5 * s + 1);
      tick();
    end
    checkOutput($sformatf("idle_after_s%0d", s), {4'h0, obs[idx]}, 16'h0);
  endtask

  task automatic runResetMid(input int idx);
    int s;
    logic [15:0] prev;
    s = (idx == 0) ? 1 : 3;
    prev = r2[idx];
    applyStimulus(idx, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    startV[idx] = 1'b1;
    tick();
    startV[idx] = 1'b0;
    for (int cyc = 1; cyc <= 2 * s + 1; cyc++) begin
      checkOutput($sformatf("rstctl_s%0d_c%0d", s, cyc), {4'h0, obs[idx]}, {4'h0, expWord(s, cyc)});
      if (cyc == 2 * s + 1) rst = 1'b0;
      tick();
    end
    checkOutput($sformatf("rst_mid_s%0d", s), {4'h0, obs[idx]}, 16'h0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("post_rst_s%0d_%0d", s, k), {4'h0, obs[idx]}, 16'h0);
    end
    checkOutput($sformatf("pronto_kept_s%0d", s), r2[idx], prev);
  endtask

  initial begin
    rst = 1'b0;
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(i, 16'h0, 16'h0, 16'h0, 16'h0);

    tick();
    tick();
    checkOutput("reset_s1", {4'h0, obs[0]}, 16'h0);
    checkOutput("reset_s3", {4'h0, obs[1]}, 16'h0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("idle_s1_%0d", k), {4'h0, obs[0]}, 16'h0);
      checkOutput($sformatf("idle_s3_%0d", k), {4'h0, obs[1]}, 16'h0);
    end

    $display("[TB] basic evaluation and second operand set");
    runEval(0, 16'd1, 16'd2, 16'd3, 16'd2, 1'b0, 1'b0);
    checkOutput("basic_eq_11", r2[0], 16'd11);
    runEval(1, 16'd3, 16'd0, 16'd5, 16'd4, 1'b0, 1'b0);
    checkOutput("second_eq_53", r2[1], 16'd53);

    $display("[TB] wrap-around");
    runEval(0, 16'd1, 16'd0, 16'd7, 16'd256, 1'b0, 1'b0);
    checkOutput("wrap_eq_7_s1", r2[0], 16'd7);
    runEval(1, 16'd1, 16'd0, 16'd7, 16'd256, 1'b0, 1'b0);
    checkOutput("wrap_eq_7_s3", r2[1], 16'd7);

    $display("[TB] start during run and back-to-back");
    for (int i = 0; i < 2; i++) begin
      runEval(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
      runEval(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
    end

    $display("[TB] reset mid-operation");
    runResetMid(0);
    runResetMid(1);

    $display("[TB] randomized evaluations");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        runEval(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
